// File: rtl/multiplexed_display_driver_if.sv
// multiplexed_display_driver_if: value/control inputs and segment/anode outputs of the display driver
interface multiplexed_display_driver_if #(
  parameter int DIGITS = 4
);
  localparam int IW = $clog2(DIGITS);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic [IW-1:0]         digit_idx;
  logic                  frame_done;
  modport master (
    output enable, load, value, dp_in,
    input  seg, dp, an, digit_idx, frame_done
  );
  modport slave (
    input  enable, load, value, dp_in,
    output seg, dp, an, digit_idx, frame_done
  );
endinterface

// File: rtl/multiplexed_display_driver.sv
// multiplexed_display_driver: time-multiplexed 7-segment scan with tear-free buffering and polarity control
module multiplexed_display_driver #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 0,
  parameter int HEX_MODE       = 0,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input logic clk,
  input logic rst,
  multiplexed_display_driver_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  localparam logic AN_INV = AN_ACTIVE_LOW != 0;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d, act_q, act_d;
  logic [DIGITS-1:0]     pdp_q, pdp_d, adp_q, adp_d;
  logic                  pv_q, pv_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [DIGITS-1:0]     lz;
  logic [3:0]            nib;
  logic                  tc, wrap, swap, blank;
  // Leading-zero map: lz[i] set when nibbles i..DIGITS-1 of the active value are all zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = act_q[4*DIGITS-1 -: 4] == 4'd0;
    for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] & (act_q[4*i +: 4] == 4'd0);
  end
  // Scan counters, tear-free buffer swap and next output levels (logic-high = lit)
  always_comb begin
    tc = pre_q == PW'(PRESCALE - 1);
    wrap = !rst && bus.enable && tc && idx_q == IW'(DIGITS - 1);
    swap = (wrap || !bus.enable) && (pv_q || bus.load);
    pre_d = bus.enable ? (tc ? '0 : pre_q + PW'(1)) : pre_q;
    idx_d = (bus.enable && tc) ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    pend_d = bus.load ? bus.value : pend_q;
    pdp_d = bus.load ? bus.dp_in : pdp_q;
    pv_d = swap ? 1'b0 : (pv_q || bus.load);
    act_d = swap ? (bus.load ? bus.value : pend_q) : act_q;
    adp_d = swap ? (bus.load ? bus.dp_in : pdp_q) : adp_q;
    nib = act_q[{idx_q, 2'b00} +: 4];
    blank = LZ_BLANK != 0 && idx_q != '0 && lz[idx_q];
    seg_d = (!bus.enable || blank || (nib > 4'd9 && HEX_MODE == 0)) ? '0 : GLYPH[nib];
    dp_d = bus.enable && adp_q[idx_q];
    an_d = (bus.enable && !(int'(pre_q) < BLANK_CYCLES)) ? DIGITS'(1) << idx_q : '0;
  end
  // State and output registers; reset drops the active value and parks outputs inactive
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      pdp_q <= '0;
      act_q <= '0;
      adp_q <= '0;
      pv_q <= 1'b0;
      seg_q <= '0;
      dp_q <= 1'b0;
      an_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      pdp_q <= pdp_d;
      act_q <= act_d;
      adp_q <= adp_d;
      pv_q <= pv_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
    end
  end
  assign bus.seg = seg_q ^ {7{SEG_INV}};
  assign bus.dp = dp_q ^ SEG_INV;
  assign bus.an = an_q ^ {DIGITS{AN_INV}};
  assign bus.digit_idx = idx_q;
  assign bus.frame_done = wrap;
endmodule

// File: tb/tb_multiplexed_display_driver.sv
// tb_multiplexed_display_driver: scoreboard bench for two driver configurations on a common timeline
module tb_multiplexed_display_driver;
  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [1:0] idx;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int c0 = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  multiplexed_display_driver_if #(.DIGITS(4)) ia ();
  multiplexed_display_driver_if #(.DIGITS(4)) ib ();
  multiplexed_display_driver #(.DIGITS(4), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  multiplexed_display_driver #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .HEX_MODE(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void ea(int m, logic [6:0] s, logic [3:0] a, logic d, logic [1:0] i, logic f);
    qa.push_back('{c0 + m, s, a, d, i, f});
  endfunction
  function automatic void eb(int m, logic [6:0] s, logic [3:0] a, logic d, logic [1:0] i, logic f);
    qb.push_back('{c0 + m, s, a, d, i, f});
  endfunction
  task automatic cmp(string nm, exp_t e, logic [6:0] s, logic [3:0] a, logic d, logic [1:0] i, logic f);
    n_cmp++;
    if ({s, a, d, i, f} !== {e.seg, e.an, e.dp, e.idx, e.fd}) begin
      n_bad++;
      $display("FAIL %s m=%0d: got seg=%b an=%b dp=%b idx=%0d fd=%b, expected seg=%b an=%b dp=%b idx=%0d fd=%b",
               nm, e.cyc - c0, s, a, d, i, f, e.seg, e.an, e.dp, e.idx, e.fd);
    end
  endtask
  // Monitor: compare every expectation due at this cycle against what the DUTs present
  initial forever begin
    @(negedge clk);
    while (qa.size() > 0 && qa[0].cyc <= cyc)
      cmp("dispA", qa.pop_front(), ia.seg, ia.an, ia.dp, ia.digit_idx, ia.frame_done);
    while (qb.size() > 0 && qb[0].cyc <= cyc)
      cmp("dispB", qb.pop_front(), ib.seg, ib.an, ib.dp, ib.digit_idx, ib.frame_done);
  end
  initial begin
    ia.enable = 0; ia.load = 0; ia.value = '0; ia.dp_in = '0;
    ib.enable = 0; ib.load = 0; ib.value = '0; ib.dp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    c0 = cyc + 1;
    ea(-1, 7'b0000000, 4'b0000, 0, 0, 0);
    eb(-1, 7'b1111111, 4'b1111, 1, 0, 0);
    rst = 0;
    ia.load = 1; ia.value = 16'h1234;
    ib.load = 1; ib.value = 16'h00FA;
    ea(1,  7'b0110011, 4'b0001, 0, 0, 0);
    ea(4,  7'b0110011, 4'b0001, 0, 1, 0);
    ea(5,  7'b1111001, 4'b0010, 0, 1, 0);
    ea(9,  7'b1101101, 4'b0100, 0, 2, 0);
    ea(13, 7'b0110000, 4'b1000, 0, 3, 0);
    ea(14, 7'b0110000, 4'b1000, 0, 3, 0);
    ea(15, 7'b0110000, 4'b1000, 0, 3, 1);
    ea(16, 7'b0110000, 4'b1000, 0, 0, 0);
    ea(17, 7'b0110011, 4'b0001, 0, 0, 0);
    ea(25, 7'b1101101, 4'b0100, 0, 2, 0);
    ea(29, 7'b0110000, 4'b1000, 0, 3, 0);
    ea(31, 7'b0110000, 4'b1000, 0, 3, 1);
    ea(32, 7'b0110000, 4'b1000, 0, 0, 0);
    ea(33, 7'b1111011, 4'b0001, 0, 0, 0);
    ea(48, 7'b1111011, 4'b1000, 0, 0, 0);
    ea(49, 7'b1111110, 4'b0001, 0, 0, 0);
    ea(53, 7'b1011011, 4'b0010, 0, 1, 0);
    ea(57, 7'b0000000, 4'b0100, 0, 2, 0);
    ea(61, 7'b0000000, 4'b1000, 1, 3, 0);
    ea(65, 7'b1111110, 4'b0001, 0, 0, 0);
    ea(69, 7'b0000000, 4'b0010, 0, 1, 0);
    ea(81, 7'b0000000, 4'b0001, 1, 0, 0);
    ea(91, 7'b0000000, 4'b0000, 0, 2, 0);
    ea(93, 7'b0000000, 4'b0000, 0, 2, 0);
    ea(94, 7'b0000000, 4'b0100, 0, 2, 0);
    ea(95, 7'b0000000, 4'b0100, 0, 3, 0);
    ea(97, 7'b0000000, 4'b0000, 0, 0, 0);
    ea(98, 7'b1111110, 4'b0001, 0, 0, 0);
    eb(1,  7'b0001000, 4'b1111, 1, 0, 0);
    eb(2,  7'b0001000, 4'b1110, 1, 0, 0);
    eb(5,  7'b0111000, 4'b1111, 1, 1, 0);
    eb(6,  7'b0111000, 4'b1101, 1, 1, 0);
    eb(10, 7'b1111111, 4'b1011, 1, 2, 0);
    eb(14, 7'b1111111, 4'b0111, 1, 3, 0);
    eb(15, 7'b1111111, 4'b0111, 1, 3, 1);
    eb(91, 7'b1111111, 4'b1111, 1, 2, 0);
    eb(97, 7'b1111111, 4'b1111, 1, 0, 0);
    eb(98, 7'b0000001, 4'b1111, 1, 0, 0);
    @(posedge clk);
    #1;
    ib.load = 0;
    ia.enable = 1; ib.enable = 1;
    for (int m = 0; m <= 100; m++) begin
      ia.load = 0;
      if (m == 20) begin ia.load = 1; ia.value = 16'h9999; ia.dp_in = 4'b0000; end
      if (m == 47) begin ia.load = 1; ia.value = 16'h0050; ia.dp_in = 4'b1000; end
      if (m == 63) begin ia.load = 1; ia.value = 16'h0000; ia.dp_in = 4'b0000; end
      if (m == 79) begin ia.load = 1; ia.value = 16'h000A; ia.dp_in = 4'b0001; end
      if (m == 90) begin ia.enable = 0; ib.enable = 0; end
      if (m == 93) begin ia.enable = 1; ib.enable = 1; end
      if (m == 96) rst = 1;
      if (m == 97) rst = 0;
      @(posedge clk);
      #1;
    end
    repeat (2) @(negedge clk);
    if (qa.size() + qb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending: %0d expectations never checked, expected 0", qa.size() + qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
